// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the AES round-pipeline stages.
//
//   Contents:
//     DIM_DEF, CELL_W_DEF  default state geometry (4 x 4 cells of 8 bits)
//     MODE_FWD, MODE_INV   values of the per-block direction bit
//     fill_state_t         occupancy of a two-entry (main + skid) stage
//     cell_lsb()           LSB position of cell (r,c) inside a packed state
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int DIM_DEF    = 4;
  localparam int CELL_W_DEF = 8;

  // Direction bit carried with every block.
  localparam logic MODE_FWD = 1'b0;  // ShiftRows     (encrypt)
  localparam logic MODE_INV = 1'b1;  // InvShiftRows  (decrypt)

  // Occupancy of a main-register + skid-register stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_ONE   = 2'd1,  // main register holds the oldest block
    ST_FULL  = 2'd2   // main and skid registers both hold blocks
  } fill_state_t;

  // Column-major packing: cell (0,0) sits at the MSBs and column 0 is the
  // most significant column. Returns the LSB index of cell (r,c).
  function automatic int cell_lsb(input int r, input int c,
                                  input int dim, input int cw);
    return cw * (dim * dim - 1 - (dim * c + r));
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// ---------------------------------------------------------------------------
// shift_rows_perm
//   Purely combinational AES ShiftRows / InvShiftRows cell permutation for a
//   DIM x DIM state of CELL_W-bit cells. Pure wiring plus one 2:1 mux per
//   cell, so it can be dropped into any datapath (e.g. key schedule).
//
//   Forward : out(r,c) = in(r, (c+r) mod DIM)      row r rotates left by r
//   Inverse : out(r,c) = in(r, (c-r+DIM) mod DIM)  row r rotates right by r
//
//   Ports:
//     state_i  in   DIM*DIM*CELL_W  state, column-major packing
//     inv_i    in   1               MODE_FWD / MODE_INV
//     state_o  out  DIM*DIM*CELL_W  permuted state, same packing
// ---------------------------------------------------------------------------
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int DIM    = DIM_DEF,
  parameter int CELL_W = CELL_W_DEF
) (
  input  logic [DIM*DIM*CELL_W-1:0] state_i,
  input  logic                      inv_i,
  output logic [DIM*DIM*CELL_W-1:0] state_o
);

  // gi walks rows, gj walks columns. All source/destination offsets are
  // elaboration-time constants, so each cell reduces to a single mux.
  genvar gi, gj;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_row
      for (gj = 0; gj < DIM; gj++) begin : g_col
        localparam int DST_LSB = cell_lsb(gi, gj, DIM, CELL_W);
        localparam int FWD_LSB = cell_lsb(gi, (gj + gi) % DIM, DIM, CELL_W);
        localparam int INV_LSB = cell_lsb(gi, (gj - gi + DIM) % DIM, DIM, CELL_W);

        assign state_o[DST_LSB +: CELL_W] = (inv_i == MODE_INV)
                                          ? state_i[INV_LSB +: CELL_W]
                                          : state_i[FWD_LSB +: CELL_W];
      end
    end
  endgenerate

endmodule

// File: rtl/shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe
//   Pipelined AES ShiftRows / InvShiftRows stage with valid/ready handshakes
//   on both sides. Each block carries its own direction bit, so a single
//   instance serves both the encrypt and decrypt datapaths. A main register
//   plus one skid register keep one block per clock flowing under
//   back-pressure while in_ready stays a pure register output.
//
//   Ports:
//     clk        in   1        rising-edge clock
//     reset      in   1        synchronous, active-high reset
//     in_valid   in   1        upstream block valid
//     in_ready   out  1        stage can accept a block this cycle
//     in_state   in   STATE_W  input state, column-major packing
//     in_inv     in   1        0 = ShiftRows, 1 = InvShiftRows
//     out_valid  out  1        output block valid
//     out_ready  in   1        downstream accepts
//     out_state  out  STATE_W  permuted state (oldest held block)
//     out_inv    out  1        direction bit that travelled with the block
//     blk_count  out  16       blocks delivered downstream, wrapping
// ---------------------------------------------------------------------------
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int DIM     = DIM_DEF,
  parameter int CELL_W  = CELL_W_DEF,
  parameter int STATE_W = DIM * DIM * CELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               out_inv,
  output logic [15:0]        blk_count
);

  // -------------------------------------------------------------------------
  // Input-side permutation. The result is captured on accept and never
  // recomputed downstream, so the output path is register-only.
  // -------------------------------------------------------------------------
  logic [STATE_W-1:0] perm_state;

  shift_rows_perm #(
    .DIM    (DIM),
    .CELL_W (CELL_W)
  ) u_perm (
    .state_i (in_state),
    .inv_i   (in_inv),
    .state_o (perm_state)
  );

  // -------------------------------------------------------------------------
  // Storage and control registers
  // -------------------------------------------------------------------------
  fill_state_t        state_reg;
  logic [STATE_W-1:0] main_state_reg;
  logic               main_inv_reg;
  logic [STATE_W-1:0] skid_state_reg;
  logic               skid_inv_reg;
  logic               out_valid_reg;
  logic               in_ready_reg;
  logic [15:0]        blk_count_reg;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready_reg;
  assign out_xfer = out_valid_reg & out_ready;

  // -------------------------------------------------------------------------
  // Occupancy FSM. Main always holds the oldest block; the skid register is
  // only filled when main is occupied and cannot drain on the same edge.
  // in_ready is registered: it falls the cycle after the skid fills and
  // rises again the cycle after the skid block moves into main.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_EMPTY;
      main_state_reg <= '0;
      main_inv_reg   <= MODE_FWD;
      skid_state_reg <= '0;
      skid_inv_reg   <= MODE_FWD;
      out_valid_reg  <= 1'b0;
      in_ready_reg   <= 1'b0;  // held low while reset is asserted
      blk_count_reg  <= 16'd0;
    end else begin
      if (out_xfer) begin
        blk_count_reg <= blk_count_reg + 16'd1;  // natural 16-bit wrap
      end

      // Only the ONE->FULL move and a stalled FULL keep the input closed.
      in_ready_reg <= 1'b1;

      case (state_reg)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_state_reg <= perm_state;
            main_inv_reg   <= in_inv;
            out_valid_reg  <= 1'b1;
            state_reg      <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            // Old block leaves while the new one replaces it in main.
            main_state_reg <= perm_state;
            main_inv_reg   <= in_inv;
          end else if (in_xfer) begin
            // Main is stalled: park the new block in the skid register.
            skid_state_reg <= perm_state;
            skid_inv_reg   <= in_inv;
            in_ready_reg   <= 1'b0;
            state_reg      <= ST_FULL;
          end else if (out_xfer) begin
            // Main keeps its last value; out_valid alone marks it stale.
            out_valid_reg  <= 1'b0;
            state_reg      <= ST_EMPTY;
          end
        end

        ST_FULL: begin
          // in_ready_reg is low here, so no input transfer can occur.
          if (out_xfer) begin
            main_state_reg <= skid_state_reg;
            main_inv_reg   <= skid_inv_reg;
            state_reg      <= ST_ONE;
          end else begin
            in_ready_reg   <= 1'b0;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= ST_EMPTY;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs are driven straight from registers.
  // -------------------------------------------------------------------------
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_state = main_state_reg;
  assign out_inv   = main_inv_reg;
  assign blk_count = blk_count_reg;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_rows_pipe
//   Directed, table-driven bench for shift_rows_pipe. Inputs change and
//   outputs are sampled on the falling clock edge; transfers happen on the
//   rising edge. A second instance with CELL_W=1 covers bit-matrix mode.
// ---------------------------------------------------------------------------
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Main instance: DIM=4, CELL_W=8
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
  logic [127:0] in_state, out_state;
  logic [15:0]  blk_count;

  // Bit-matrix instance: DIM=4, CELL_W=1
  logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
  logic [15:0]  b_in_state, b_out_state;
  logic [15:0]  b_blk_count;

  shift_rows_pipe #(.DIM(4), .CELL_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_inv   (out_inv),
    .blk_count (blk_count)
  );

  shift_rows_pipe #(.DIM(4), .CELL_W(1)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_state  (b_in_state),
    .in_inv    (b_in_inv),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_state (b_out_state),
    .out_inv   (b_out_inv),
    .blk_count (b_blk_count)
  );

  typedef struct {
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Hand-computed vectors; entries alternate direction.
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 1'b0,
                128'h0055aaff4499ee3388dd2277cc1166bb};
    vecs[1] = '{128'h0055aaff4499ee3388dd2277cc1166bb, 1'b1,
                128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                128'h00050a0f04090e03080d02070c01060b};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                128'h000d0a0704010e0b0805020f0c090603};

    reset = 1'b1;
    in_valid = 1'b0; in_state = '0; in_inv = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_state = '0; b_in_inv = 1'b0; b_out_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(0));
    check("rst_out_state", out_state,       128'(0));
    check("rst_blk_count", 128'(blk_count), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    $display("reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // ---------------- back-pressure A, B, C ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = vecs[0].st; in_inv = vecs[0].inv;   // A
    @(negedge clk);
    check("bp_A_out_valid", 128'(out_valid), 128'(1));
    check("bp_A_in_ready",  128'(in_ready),  128'(1));
    check("bp_A_state",     out_state,       vecs[0].exp);
    in_state = vecs[1].st; in_inv = vecs[1].inv;                     // B
    @(negedge clk);
    check("bp_B_in_ready", 128'(in_ready), 128'(0));
    check("bp_B_hold",     out_state,      vecs[0].exp);
    in_state = vecs[2].st; in_inv = vecs[2].inv;                     // C
    @(negedge clk);
    check("bp_C_in_ready", 128'(in_ready), 128'(0));
    check("bp_C_hold",     out_state,      vecs[0].exp);
    check("bp_C_hold_inv", 128'(out_inv),  128'(vecs[0].inv));
    $display("backpressure: held out_state=%h in_ready=%0d", out_state, in_ready);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_B",     out_state,       vecs[1].exp);
    check("bp_drain_B_inv", 128'(out_inv),   128'(vecs[1].inv));
    check("bp_reopen",      128'(in_ready),  128'(1));
    check("bp_count1",      128'(blk_count), 128'(1));
    @(negedge clk);                                                  // C accepted above
    check("bp_drain_C",  out_state,        vecs[2].exp);
    check("bp_C_valid",  128'(out_valid),  128'(1));
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_empty",  128'(out_valid), 128'(0));
    check("bp_count3", 128'(blk_count), 128'(3));
    $display("backpressure: drained blk_count=%0d", blk_count);

    // ---------------- table-driven single blocks ----------------
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_state = vecs[i].st; in_inv = vecs[i].inv;
      out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(1));
      check($sformatf("vec%0d_state", i), out_state,       vecs[i].exp);
      check($sformatf("vec%0d_inv", i),   128'(out_inv),   128'(vecs[i].inv));
      in_valid = 1'b0;
      in_state = 'x;  // X on an idle input must not reach the output
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), 128'(out_valid), 128'(0));
      $display("vec%0d: in=%h inv=%0d out=%h", i, vecs[i].st, vecs[i].inv, out_state);
    end
    in_state = '0;
    @(negedge clk);
    check("x_no_propagate", out_state, vecs[3].exp);

    // ---------------- bit-matrix mode ----------------
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_state = 16'b1011001000001111; b_in_inv = 1'b0;
    @(negedge clk);
    check("bit_fwd",     128'(b_out_state), 128'(16'h936A));
    check("bit_fwd_inv", 128'(b_out_inv),   128'(0));
    b_in_inv = 1'b1;
    @(negedge clk);
    check("bit_inv",     128'(b_out_state), 128'(16'hC23B));
    check("bit_inv_inv", 128'(b_out_inv),   128'(1));
    b_in_valid = 1'b0;
    $display("bitmatrix: out=%h", b_out_state);

    // ---------------- full throughput, 20 blocks ----------------
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k >= 1) begin
        check($sformatf("tp%0d_valid", k - 1), 128'(out_valid), 128'(1));
        check($sformatf("tp%0d_state", k - 1), out_state, vecs[(k - 1) % 4].exp);
        check($sformatf("tp%0d_inv", k - 1),   128'(out_inv), 128'(vecs[(k - 1) % 4].inv));
        $display("tp beat %0d: out=%h inv=%0d", k - 1, out_state, out_inv);
      end
      check($sformatf("tp%0d_in_ready", k), 128'(in_ready), 128'(1));
      if (k < 20) begin
        in_valid = 1'b1; in_state = vecs[k % 4].st; in_inv = vecs[k % 4].inv;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("tp_done_valid", 128'(out_valid), 128'(0));
    check("tp_count20",    128'(blk_count), 128'(20));

    // ---------------- reset from FULL ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = vecs[0].st; in_inv = vecs[0].inv;
    @(negedge clk);
    in_state = vecs[1].st; in_inv = vecs[1].inv;
    @(negedge clk);
    check("full_in_ready", 128'(in_ready), 128'(0));
    reset = 1'b1;
    out_ready = 1'b1;
    in_state = vecs[2].st; in_inv = vecs[2].inv;  // offered during reset
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_in_ready",  128'(in_ready),  128'(0));
    check("midrst_out_state", out_state,       128'(0));
    check("midrst_out_inv",   128'(out_inv),   128'(0));
    check("midrst_blk_count", 128'(blk_count), 128'(0));
    reset = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst_stale%0d", k), 128'(out_valid), 128'(0));
      check($sformatf("midrst_ready%0d", k), 128'(in_ready),  128'(1));
    end
    $display("midreset: out_valid=%0d blk_count=%0d", out_valid, blk_count);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
